// File: rtl/mem_port_arbiter.sv
// Shares the CVP14 16-bit memory port between instruction fetch and the vector burst engine.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin ties (default: fetch wins ties).
module mem_port_arbiter (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_done,
    output logic [15:0] f_rdata,
    input  logic        v_req,
    input  logic        v_we,
    input  logic [15:0] v_addr,
    input  logic [3:0]  v_len,
    input  logic [15:0] v_wdata,
    output logic [3:0]  v_idx,
    output logic        v_wbeat,
    output logic        v_rvalid,
    output logic [3:0]  v_ridx,
    output logic [15:0] v_rdata,
    output logic        v_done,
    output logic [15:0] Addr,
    output logic        RD,
    output logic        WR,
    output logic [15:0] dataOut,
    input  logic [15:0] DataIn
);

    localparam int unsigned AW = 16;
    localparam int unsigned IW = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        F_RD   = 3'd1,
        F_DATA = 3'd2,
        V_WR   = 3'd3,
        V_RD   = 3'd4,
        V_TAIL = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] len_q, len_d;
    logic [AW-1:0] base_q, base_d;

    logic [AW-1:0] addr_q, addr_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          f_done_q, f_done_d;
    logic          wbeat_q, wbeat_d;
    logic          rvalid_q, rvalid_d;
    logic [IW-1:0] ridx_q, ridx_d;
    logic [IW-1:0] vidx_q, vidx_d;
    logic          v_done_q, v_done_d;

    logic grant_f;
    logic grant_v;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic vec_last_q, vec_last_d;

    // On a tie the requester that did not win the previous grant goes next.
    assign grant_f = f_req && (!v_req || vec_last_q);
`else
    assign grant_f = f_req;
`endif
    assign grant_v = v_req && !grant_f;

    // Next-state and captured-register logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        base_d  = base_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        vec_last_d = vec_last_q;
`endif
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (grant_f) begin
                    state_d = F_RD;
                    base_d  = f_addr;
                    len_d   = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    vec_last_d = 1'b0;
`endif
                end else if (grant_v) begin
                    state_d = v_we ? V_WR : V_RD;
                    base_d  = v_addr;
                    len_d   = v_len;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    vec_last_d = 1'b1;
`endif
                end
            end
            F_RD:   state_d = F_DATA;
            F_DATA: state_d = IDLE;
            V_WR: begin
                if (idx_q == len_q) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            V_RD: begin
                if (idx_q == len_q) begin
                    state_d = V_TAIL;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            V_TAIL: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Port controls are registered: decoded from the state being entered.
    always_comb begin
        addr_d   = addr_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        f_done_d = 1'b0;
        wbeat_d  = 1'b0;
        rvalid_d = 1'b0;
        ridx_d   = '0;
        vidx_d   = idx_d;
        v_done_d = 1'b0;
        unique case (state_d)
            F_RD: begin
                rd_d   = 1'b1;
                addr_d = base_d;
            end
            F_DATA: f_done_d = 1'b1;
            V_WR: begin
                wr_d     = 1'b1;
                wbeat_d  = 1'b1;
                addr_d   = base_d + AW'(idx_d);
                v_done_d = (idx_d == len_d);
            end
            V_RD: begin
                rd_d   = 1'b1;
                addr_d = base_d + AW'(idx_d);
                if (idx_d != '0) begin
                    rvalid_d = 1'b1;
                    ridx_d   = idx_d - IW'(1);
                end
            end
            V_TAIL: begin
                rvalid_d = 1'b1;
                ridx_d   = len_d;
                v_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, captured registers and registered outputs; Reset abandons any burst.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            base_q   <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            f_done_q <= 1'b0;
            wbeat_q  <= 1'b0;
            rvalid_q <= 1'b0;
            ridx_q   <= '0;
            vidx_q   <= '0;
            v_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            f_done_q <= f_done_d;
            wbeat_q  <= wbeat_d;
            rvalid_q <= rvalid_d;
            ridx_q   <= ridx_d;
            vidx_q   <= vidx_d;
            v_done_q <= v_done_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Reset value means "vector won last", so the first tie goes to fetch.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            vec_last_q <= 1'b1;
        end else begin
            vec_last_q <= vec_last_d;
        end
    end
`endif

    assign Addr     = addr_q;
    assign RD       = rd_q;
    assign WR       = wr_q;
    assign f_done   = f_done_q;
    assign v_wbeat  = wbeat_q;
    assign v_rvalid = rvalid_q;
    assign v_ridx   = ridx_q;
    assign v_idx    = vidx_q;
    assign v_done   = v_done_q;

    // Data paths pass through, gated to zero outside their valid cycles.
    assign dataOut = wr_q     ? v_wdata : '0;
    assign f_rdata = f_done_q ? DataIn  : '0;
    assign v_rdata = rvalid_q ? DataIn  : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model with per-cycle compare plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int K_NONE = 0;
    localparam int K_F    = 1;
    localparam int K_W    = 2;
    localparam int K_R    = 3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic [2:0] TIE_EXP = 3'b010;
`else
    localparam logic [2:0] TIE_EXP = 3'b111;
`endif

    logic        Clk1 = 1'b0;
    logic        Reset = 1'b1;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = 16'h0;
    logic        f_done;
    logic [15:0] f_rdata;
    logic        v_req = 1'b0;
    logic        v_we = 1'b0;
    logic [15:0] v_addr = 16'h0;
    logic [3:0]  v_len = 4'h0;
    logic [15:0] v_wdata;
    logic [3:0]  v_idx;
    logic        v_wbeat;
    logic        v_rvalid;
    logic [3:0]  v_ridx;
    logic [15:0] v_rdata;
    logic        v_done;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic [15:0] dataOut;
    logic [15:0] DataIn = 16'h0;

    logic [15:0] wdata_base = 16'h1000;
    int errors = 0;
    int checks = 0;

    mem_port_arbiter dut (
        .Clk1(Clk1), .Reset(Reset),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
        .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_len(v_len),
        .v_wdata(v_wdata), .v_idx(v_idx), .v_wbeat(v_wbeat),
        .v_rvalid(v_rvalid), .v_ridx(v_ridx), .v_rdata(v_rdata), .v_done(v_done),
        .Addr(Addr), .RD(RD), .WR(WR), .dataOut(dataOut), .DataIn(DataIn)
    );

    always #5 Clk1 = ~Clk1;

    // The vector requester supplies element data as a function of the element index.
    assign v_wdata = wdata_base + 16'(v_idx);

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hABCD : (a ^ 16'hC35A);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: read data appears the cycle after an RD cycle.
    logic        rd_s = 1'b0;
    logic [15:0] a_s = 16'h0;
    always @(negedge Clk1) begin
        rd_s = RD;
        a_s  = Addr;
    end
    always @(posedge Clk1) begin
        #1;
        DataIn = rd_s ? mem_word(a_s) : 16'h0;
    end

    // Model: current transaction plus cycle offset since its grant.
    int          m_kind = K_NONE;
    int          m_t = 0;
    int          m_len = 0;
    logic [15:0] m_base = 16'h0;
    logic [15:0] m_last_addr = 16'h0;
    bit          m_vec_last = 1'b1;
    bit          m_pick_f;
    bit          started = 1'b0;

    logic        e_rd, e_wr, e_fd, e_wb, e_rv, e_dn, e_beat;
    logic [15:0] e_addr, e_dout, e_rdat;
    logic [3:0]  e_idx, e_ridx;

    function automatic int txn_cycles(input int kind, input int len);
        if (kind == K_F) return 2;
        if (kind == K_W) return len + 1;
        return len + 2;
    endfunction

    always @(posedge Clk1) begin
        started = 1'b1;
        if (Reset) begin
            m_kind = K_NONE; m_t = 0; m_len = 0; m_base = 16'h0;
            m_last_addr = 16'h0; m_vec_last = 1'b1;
        end else if (m_kind != K_NONE) begin
            if (m_t == txn_cycles(m_kind, m_len)) begin
                m_kind = K_NONE; m_t = 0;
            end else begin
                m_t++;
            end
        end else if (f_req || v_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            m_pick_f = f_req && (!v_req || m_vec_last);
`else
            m_pick_f = f_req;
`endif
            m_vec_last = !m_pick_f;
            if (m_pick_f) begin
                m_kind = K_F; m_base = f_addr; m_len = 0;
            end else begin
                m_kind = v_we ? K_W : K_R; m_base = v_addr; m_len = int'(v_len);
            end
            m_t = 1;
        end
        e_rd = 0; e_wr = 0; e_fd = 0; e_wb = 0; e_rv = 0; e_dn = 0; e_beat = 0;
        e_addr = m_last_addr; e_dout = 16'h0; e_rdat = 16'h0; e_idx = 4'h0; e_ridx = 4'h0;
        case (m_kind)
            K_F: begin
                e_addr = m_base;
                if (m_t == 1) e_rd = 1;
                else begin e_fd = 1; e_rdat = mem_word(m_base); end
            end
            K_W: begin
                e_wr = 1; e_wb = 1; e_beat = 1;
                e_addr = m_base + 16'(m_t - 1);
                e_idx  = 4'(m_t - 1);
                e_dout = wdata_base + 16'(m_t - 1);
                e_dn   = (m_t == m_len + 1);
            end
            K_R: begin
                if (m_t <= m_len + 1) begin
                    e_rd = 1; e_beat = 1;
                    e_addr = m_base + 16'(m_t - 1);
                    e_idx  = 4'(m_t - 1);
                end else begin
                    e_addr = m_base + 16'(m_len);
                end
                if (m_t >= 2) begin
                    e_rv = 1;
                    e_ridx = 4'(m_t - 2);
                    e_rdat = mem_word(m_base + 16'(m_t - 2));
                end
                e_dn = (m_t == m_len + 2);
            end
            default: ;
        endcase
        m_last_addr = e_addr;
    end

    // Per-cycle compare against the model.
    always @(negedge Clk1) begin
        if (started) begin
            chk("m_RD", 32'(RD), 32'(e_rd));
            chk("m_WR", 32'(WR), 32'(e_wr));
            chk("m_Addr", 32'(Addr), 32'(e_addr));
            chk("m_dataOut", 32'(dataOut), 32'(e_dout));
            chk("m_f_done", 32'(f_done), 32'(e_fd));
            chk("m_v_wbeat", 32'(v_wbeat), 32'(e_wb));
            chk("m_v_rvalid", 32'(v_rvalid), 32'(e_rv));
            chk("m_v_done", 32'(v_done), 32'(e_dn));
            if (e_fd) chk("m_f_rdata", 32'(f_rdata), 32'(e_rdat));
            if (e_rv) begin
                chk("m_v_ridx", 32'(v_ridx), 32'(e_ridx));
                chk("m_v_rdata", 32'(v_rdata), 32'(e_rdat));
            end
            if (e_beat) chk("m_v_idx", 32'(v_idx), 32'(e_idx));
        end
    end

    task automatic run_vec(input logic we, input logic [15:0] a, input logic [3:0] l);
        int cyc;
        cyc = 0;
        @(posedge Clk1); #1;
        v_req = 1'b1; v_we = we; v_addr = a; v_len = l;
        do begin
            @(negedge Clk1);
            cyc++;
        end while (!v_done && cyc < 50);
        chk("vec_done_seen", 32'(v_done), 32'd1);
        @(posedge Clk1); #1;
        v_req = 1'b0;
    endtask

    initial begin
        int n;
        int cyc;
        int cnt;
        logic [2:0] seq;
        logic [15:0] ra [3];
        ra[0] = 16'hFFFE; ra[1] = 16'hFFFF; ra[2] = 16'h0000;

        repeat (3) @(posedge Clk1);
        #1 Reset = 1'b0;
        @(negedge Clk1);
        chk("rst_RD", 32'(RD), 32'd0);
        chk("rst_WR", 32'(WR), 32'd0);
        chk("rst_Addr", 32'(Addr), 32'd0);
        chk("rst_dataOut", 32'(dataOut), 32'd0);
        chk("rst_v_idx", 32'(v_idx), 32'd0);
        chk("rst_done", 32'({f_done, v_done, v_rvalid, v_wbeat}), 32'd0);

        // Single fetch.
        @(posedge Clk1); #1;
        f_req = 1'b1; f_addr = 16'h0010;
        @(negedge Clk1);
        @(negedge Clk1);
        chk("fetch_RD", 32'(RD), 32'd1);
        chk("fetch_Addr", 32'(Addr), 32'h0010);
        @(negedge Clk1);
        chk("fetch_done", 32'(f_done), 32'd1);
        chk("fetch_rdata", 32'(f_rdata), 32'hABCD);
        chk("fetch_RD_low", 32'(RD), 32'd0);
        @(posedge Clk1); #1;
        f_req = 1'b0;
        @(negedge Clk1);
        chk("fetch_idle_done", 32'(f_done), 32'd0);
        chk("fetch_idle_Addr", 32'(Addr), 32'h0010);

        // Tie: both requesters held high across three completions.
        @(posedge Clk1); #1;
        f_req = 1'b1; f_addr = 16'h0200;
        v_req = 1'b1; v_we = 1'b0; v_addr = 16'h0300; v_len = 4'd0;
        n = 0; cyc = 0; seq = 3'b000;
        while (n < 3 && cyc < 40) begin
            @(negedge Clk1);
            cyc++;
            if (f_done) begin seq = {seq[1:0], 1'b1}; n++; end
            else if (v_done) begin seq = {seq[1:0], 1'b0}; n++; end
        end
        chk("tie_completed", 32'(n), 32'd3);
        chk("tie_order", 32'(seq), 32'(TIE_EXP));
        @(posedge Clk1); #1;
        f_req = 1'b0; v_req = 1'b0;

        // Write burst of four.
        @(posedge Clk1); #1;
        wdata_base = 16'h1000;
        v_req = 1'b1; v_we = 1'b1; v_addr = 16'h0100; v_len = 4'd3;
        @(negedge Clk1);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk1);
            chk("wr_WR", 32'(WR), 32'd1);
            chk("wr_RD", 32'(RD), 32'd0);
            chk("wr_Addr", 32'(Addr), 32'h0100 + 32'(i));
            chk("wr_dataOut", 32'(dataOut), 32'h1000 + 32'(i));
            chk("wr_done", 32'(v_done), 32'(i == 3));
        end
        @(posedge Clk1); #1;
        v_req = 1'b0;
        @(negedge Clk1);
        chk("wr_idle_WR", 32'(WR), 32'd0);
        chk("wr_idle_dataOut", 32'(dataOut), 32'd0);

        // Read burst wrapping through 0xFFFF.
        @(posedge Clk1); #1;
        v_req = 1'b1; v_we = 1'b0; v_addr = 16'hFFFE; v_len = 4'd2;
        @(negedge Clk1);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk1);
            chk("rd_RD", 32'(RD), 32'(i < 3));
            if (i < 3) chk("rd_Addr", 32'(Addr), 32'(ra[i]));
            chk("rd_rvalid", 32'(v_rvalid), 32'(i >= 1));
            if (i >= 1) chk("rd_ridx", 32'(v_ridx), 32'(i - 1));
            chk("rd_done", 32'(v_done), 32'(i == 3));
        end
        @(posedge Clk1); #1;
        v_req = 1'b0;

        // Reset during beat 5 of a 16-beat read, with a fetch request raised alongside it.
        @(posedge Clk1); #1;
        v_req = 1'b1; v_we = 1'b0; v_addr = 16'h2000; v_len = 4'd15;
        @(negedge Clk1);
        repeat (4) @(negedge Clk1);
        @(posedge Clk1); #1;
        Reset = 1'b1; f_req = 1'b1; f_addr = 16'h0555;
        @(negedge Clk1);
        chk("rst_beat5_RD", 32'(RD), 32'd1);
        chk("rst_beat5_Addr", 32'(Addr), 32'h2004);
        @(posedge Clk1); #1;
        Reset = 1'b0; f_req = 1'b0; v_req = 1'b0;
        @(negedge Clk1);
        chk("rst_mid_RD", 32'(RD), 32'd0);
        chk("rst_mid_rvalid", 32'(v_rvalid), 32'd0);
        chk("rst_mid_Addr", 32'(Addr), 32'd0);
        cnt = 0;
        repeat (20) begin
            @(negedge Clk1);
            if (v_done || f_done) cnt++;
        end
        chk("rst_no_done", 32'(cnt), 32'd0);

        // Mid-burst changes to v_len/v_addr/v_we are ignored.
        @(posedge Clk1); #1;
        wdata_base = 16'h7700;
        v_req = 1'b1; v_we = 1'b1; v_addr = 16'h3000; v_len = 4'd15;
        @(negedge Clk1);
        cnt = 0; cyc = 0;
        while (!v_done && cyc < 40) begin
            @(negedge Clk1);
            cyc++;
            if (WR) cnt++;
            if (cyc == 3) begin
                @(posedge Clk1); #1;
                v_len = 4'd0; v_addr = 16'h9999; v_we = 1'b0;
            end
        end
        chk("chg_beats", 32'(cnt), 32'd16);
        chk("chg_last_Addr", 32'(Addr), 32'h300F);
        @(posedge Clk1); #1;
        v_req = 1'b0;

        // Fetch held high: each cycle after f_done starts a new fetch.
        @(posedge Clk1); #1;
        f_req = 1'b1; f_addr = 16'h0042;
        cnt = 0;
        repeat (9) begin
            @(negedge Clk1);
            if (f_done) cnt++;
        end
        chk("hold_fetches", 32'(cnt), 32'd3);
        @(posedge Clk1); #1;
        f_req = 1'b0;

        // Single-beat and long wrapping bursts, checked by the model.
        run_vec(1'b1, 16'hFFFF, 4'd0);
        run_vec(1'b0, 16'h0500, 4'd0);
        run_vec(1'b0, 16'hFFF8, 4'd15);
        run_vec(1'b1, 16'hFFFA, 4'd9);

        repeat (4) @(negedge Clk1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
